// File: rtl/adder_chk_pkg.sv
// Shared types and defaults for the adder result checker.
package adder_chk_pkg;

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefCntW  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StCheck,
    StDone
  } chk_state_e;

endpackage

// File: rtl/adder_result_checker_if.sv
// Operand tap, adder output and result readback for the adder result checker.
interface adder_result_checker_if #(
  parameter int unsigned WIDTH = adder_chk_pkg::DefWidth,
  parameter int unsigned CNT_W = adder_chk_pkg::DefCntW
);

  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH:0]   Z;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_count;
  logic [CNT_W-1:0] err_count;
  logic             first_err_valid;
  logic [WIDTH-1:0] first_err_a;
  logic [WIDTH-1:0] first_err_b;
  logic [WIDTH:0]   first_err_z;

  modport master (
    output start, num_samples, A, B, Z,
    input  busy, done, sample_count, err_count,
    input  first_err_valid, first_err_a, first_err_b, first_err_z
  );

  modport slave (
    input  start, num_samples, A, B, Z,
    output busy, done, sample_count, err_count,
    output first_err_valid, first_err_a, first_err_b, first_err_z
  );

endinterface

// File: rtl/operand_delay_line.sv
// Free-running shift register that aligns the tapped operands with the adder output.
module operand_delay_line #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned DW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] stage_q [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= din;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[LATENCY-1];

endmodule

// File: rtl/adder_result_checker.sv
// Compares a registered adder's sum against a local reference over a programmed run.
module adder_result_checker
  import adder_chk_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = DefCntW
) (
  input logic                   clk,
  input logic                   rst_n,
  adder_result_checker_if.slave chk
);

  localparam int unsigned FillW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [FillW-1:0] FillLast = FillW'((LATENCY > 1) ? LATENCY - 2 : 0);

  logic [2*WIDTH-1:0] ab_dly;
  logic [WIDTH-1:0]   a_dly, b_dly;
  logic [WIDTH:0]     exp_sum;
  logic               mismatch;

  chk_state_e       state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d;
  logic [WIDTH:0]   fz_q, fz_d;
  logic             busy_q, busy_d, done_q, done_d;

  operand_delay_line #(
    .LATENCY (LATENCY),
    .DW      (2 * WIDTH)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({chk.A, chk.B}),
    .dout  (ab_dly)
  );

  assign a_dly    = ab_dly[2*WIDTH-1:WIDTH];
  assign b_dly    = ab_dly[WIDTH-1:0];
  assign exp_sum  = {1'b0, a_dly} + {1'b0, b_dly};
  assign mismatch = (chk.Z != exp_sum);

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fz_d    = fz_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (chk.start) begin
          num_d  = chk.num_samples;
          fill_d = '0;
          cnt_d  = '0;
          err_d  = '0;
          fv_d   = 1'b0;
          fa_d   = '0;
          fb_d   = '0;
          fz_d   = '0;
          if (chk.num_samples == '0) begin
            state_d = StDone;
          end else if (LATENCY == 1) begin
            state_d = StCheck;
          end else begin
            state_d = StFill;
          end
        end
      end
      StFill: begin
        fill_d = fill_q + 1'b1;
        if (fill_q == FillLast) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        cnt_d = cnt_q + 1'b1;
        if (mismatch) begin
          err_d = err_q + 1'b1;
          // Only the first failing vector is kept for readback.
          if (!fv_q) begin
            fv_d = 1'b1;
            fa_d = a_dly;
            fb_d = b_dly;
            fz_d = chk.Z;
          end
        end
        if (cnt_d == num_q) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StFill) || (state_d == StCheck);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      num_q   <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
      fz_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fz_q    <= fz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign chk.busy            = busy_q;
  assign chk.done            = done_q;
  assign chk.sample_count    = cnt_q;
  assign chk.err_count       = err_q;
  assign chk.first_err_valid = fv_q;
  assign chk.first_err_a     = fa_q;
  assign chk.first_err_b     = fb_q;
  assign chk.first_err_z     = fz_q;

endmodule

// File: doc/adder_result_checker.md
# adder_result_checker

Clocked result checker that sits directly downstream of the clocked 4-bit adder demo block. It taps the same operands driven into the adder, delays them to match the adder's latency, and compares the adder's registered sum against a locally computed reference for a programmed number of samples. It reports a mismatch count and the first failing vector, giving Spacely-Caribou / cocotb tests a single pass/fail summary to read back.

## Interface
- `WIDTH`, default 4, operand width; the sum is `WIDTH+1` bits.
- `LATENCY`, default 1, adder latency in clock edges, minimum 1.
- `CNT_W`, default 16, width of sample and error counters.
- `clk`  in  1  rising-edge clock, the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a check run.
- `num_samples`  in  CNT_W  number of sums to check; sampled on the `start` edge.
- `A`  in  WIDTH  operand A, as driven to the adder.
- `B`  in  WIDTH  operand B, as driven to the adder.
- `Z`  in  WIDTH+1  registered adder output.
- `busy`  out  1  run in progress.
- `done`  out  1  run complete; results stable.
- `sample_count`  out  CNT_W  number of compares performed.
- `err_count`  out  CNT_W  number of mismatching compares.
- `first_err_valid`  out  1  at least one mismatch captured.
- `first_err_a`, `first_err_b`  out  WIDTH  operands of the first mismatch.
- `first_err_z`  out  WIDTH+1  adder output at the first mismatch.

## Operation
- Operand delay line: `LATENCY` stages, free-running. It shifts `{A,B}` on every edge, including in IDLE.
- Expected sum = zero-extended delayed A + delayed B, computed at `WIDTH+1` bits with no truncation.
- FSM states: IDLE, FILL, CHECK, DONE.
  - IDLE/DONE → FILL on `start`. If `LATENCY==1`, go straight to CHECK. If `num_samples==0`, go straight to DONE.
  - FILL lasts `LATENCY-1` cycles, then → CHECK.
  - CHECK compares every cycle. After compare number `num_samples` → DONE.
  - DONE holds until the next `start`.
- On an accepted `start`:
  - clear `sample_count`, `err_count`, `first_err_*` and `done`;
  - latch `num_samples`.
- `start` in FILL or CHECK is ignored. `start` in DONE restarts the run.
- Sample k is the operand pair present at start edge E0 + k. It is compared at edge E(k+LATENCY).
- Each compare increments `sample_count`. On a mismatch, `err_count` increments.
- On the first mismatch only, `first_err_*` latch the delayed operands and `Z`, and `first_err_valid` is set. Later mismatches do not overwrite them.
- `busy` = state is FILL or CHECK.
- Reset values: all outputs 0, state IDLE, delay line 0.
- Reset asserted mid-run: everything clears immediately and asynchronously. No partial results are retained.

## Timing
- All outputs are registered.
- `busy` rises on edge E0 (the `start` edge) and falls on edge E(num_samples+LATENCY-1).
- `done` rises on that same edge, E(num_samples+LATENCY-1).
- `num_samples==0`: `done` is high after edge E0 and `busy` never asserts.
- Counters and `first_err_*` update on the compare edge. They are valid in the cycle after that edge.
- Throughput: one compare per cycle, with no bubbles.

## Structure
- Package `adder_chk_pkg` holds:
  - the state enum typedef (IDLE, FILL, CHECK, DONE);
  - default `WIDTH` and `CNT_W` localparams.
- Sub-module `operand_delay_line`: a parameterised `{A,B}` shift register of depth `LATENCY` with async active-low reset.
- Top level contains the FSM, the comparator, the counters and the capture registers.

## Test plan
- Correct adder, exhaustive sweep (A outer, B inner, 0..15), `num_samples=256` → `done` at edge E256, `sample_count=256`, `err_count=0`, `first_err_valid=0`.
- Adder built with its carry-error option (sum truncated to 4 bits), same sweep → `err_count=120`, `first_err_a=1`, `first_err_b=15`, `first_err_z=5'h00`.
- `num_samples=0` → `done=1` one cycle after `start`, `busy` never high, all counts 0.
- `rst_n` pulsed low after 10 compares → all outputs 0 immediately. A new `start` then completes a clean 16-sample run with `err_count=0`.
- Second `start` during CHECK → ignored and the run finishes unchanged. `start` in DONE → counters clear and a new run starts.
- `LATENCY=2` with a two-stage model adder, 32 random vectors → `err_count=0`. `busy` lasts 33 cycles and `done` is at edge E33.
